// File: rtl/insn_decoder.sv
// Instruction decoder with a one-entry skid buffer and a RUN/HALT intake FSM.
// Optional illegal-opcode flagging is enabled by defining INSN_DECODER_ILLEGAL_EN.
module insn_decoder #(
  parameter int LEN_INSN = 32,
  parameter int LEN_OPC  = 6,
  parameter int LEN_REG  = 5,
  parameter int LEN_IMM  = 16,
  parameter logic [LEN_OPC-1:0] OPC_HALT = 6'h3F,
  parameter logic [LEN_OPC-1:0] OPC_MAX  = 6'h1F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                stall_o,
  input  logic [LEN_INSN-1:0] insn,
  output logic                valid_o,
  input  logic                stall_i,
  output logic [LEN_OPC-1:0]  opcode,
  output logic [LEN_REG-1:0]  rd,
  output logic [LEN_REG-1:0]  rs,
  output logic [LEN_INSN-1:0] imm,
  output logic                is_halt,
  output logic                illegal,
  output logic                halted
);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic                stall_q, stall_d;
  logic                skid_full_q, skid_full_d;
  logic [LEN_INSN-1:0] skid_q, skid_d;
  logic [LEN_OPC-1:0]  opcode_q, opcode_d;
  logic [LEN_REG-1:0]  rd_q, rd_d, rs_q, rs_d;
  logic [LEN_INSN-1:0] imm_q, imm_d;
  logic                is_halt_q, is_halt_d;
  logic                illegal_q, illegal_d;

  logic                xfer_in, out_load;
  logic [LEN_INSN-1:0] src;
  logic [LEN_OPC-1:0]  src_opc;

`ifndef INSN_DECODER_ILLEGAL_EN
  logic unused_opc_max;
  assign unused_opc_max = ^OPC_MAX;
`endif

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    skid_full_d = skid_full_q;
    skid_d      = skid_q;
    opcode_d    = opcode_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    imm_d       = imm_q;
    is_halt_d   = is_halt_q;
    illegal_d   = illegal_q;

    xfer_in  = valid_i & ~stall_q;
    out_load = ~valid_q | ~stall_i;
    // A full skid forces stall_o, so skid drain and fresh intake never coincide.
    src      = skid_full_q ? skid_q : insn;
    src_opc  = src[LEN_INSN-1 -: LEN_OPC];

    if (out_load) begin
      if (skid_full_q || xfer_in) begin
        valid_d     = 1'b1;
        skid_full_d = 1'b0;
        opcode_d    = src_opc;
        rd_d        = src[LEN_INSN-LEN_OPC-1 -: LEN_REG];
        rs_d        = src[LEN_INSN-LEN_OPC-LEN_REG-1 -: LEN_REG];
        imm_d       = {{(LEN_INSN-LEN_IMM){src[LEN_IMM-1]}}, src[LEN_IMM-1:0]};
        is_halt_d   = (src_opc == OPC_HALT);
`ifdef INSN_DECODER_ILLEGAL_EN
        illegal_d   = (src_opc > OPC_MAX) && (src_opc != OPC_HALT);
`else
        illegal_d   = 1'b0;
`endif
      end else begin
        valid_d = 1'b0;
      end
    end else if (xfer_in) begin
      skid_d      = insn;
      skid_full_d = 1'b1;
    end

    if (xfer_in && (insn[LEN_INSN-1 -: LEN_OPC] == OPC_HALT)) begin
      state_d = ST_HALT;
    end

    stall_d = skid_full_d | (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      valid_q     <= 1'b0;
      stall_q     <= 1'b0;
      skid_full_q <= 1'b0;
      skid_q      <= '0;
      opcode_q    <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      imm_q       <= '0;
      is_halt_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      stall_q     <= stall_d;
      skid_full_q <= skid_full_d;
      skid_q      <= skid_d;
      opcode_q    <= opcode_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      imm_q       <= imm_d;
      is_halt_q   <= is_halt_d;
      illegal_q   <= illegal_d;
    end
  end

  assign valid_o = valid_q;
  assign stall_o = stall_q;
  assign opcode  = opcode_q;
  assign rd      = rd_q;
  assign rs      = rs_q;
  assign imm     = imm_q;
  assign is_halt = is_halt_q;
  assign illegal = illegal_q;
  assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_insn_decoder.sv
// Scoreboard bench for insn_decoder: driver queues expected decodes on each accepted
// word; a negedge monitor pops and compares on every output transfer.
module tb_insn_decoder;

  logic        clk = 1'b0;
  logic        rst, valid_i, stall_i;
  logic [31:0] insn;
  logic        stall_o, valid_o, is_halt, illegal, halted;
  logic [5:0]  opcode;
  logic [4:0]  rd, rs;
  logic [31:0] imm;

  insn_decoder #(.LEN_INSN(32), .LEN_OPC(6), .LEN_REG(5), .LEN_IMM(16),
                 .OPC_HALT(6'h3F), .OPC_MAX(6'h1F)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_o(stall_o), .insn(insn),
    .valid_o(valid_o), .stall_i(stall_i), .opcode(opcode), .rd(rd), .rs(rs),
    .imm(imm), .is_halt(is_halt), .illegal(illegal), .halted(halted));

  always #5 clk = ~clk;

`ifdef INSN_DECODER_ILLEGAL_EN
  localparam logic ILL_ON = 1'b1;
`else
  localparam logic ILL_ON = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [31:0] imm;
    logic        halt;
    logic        ill;
  } exp_t;

  logic [31:0] v_insn [10];
  exp_t        v_exp  [10];
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && valid_o === 1'b1 && stall_i === 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got opcode %0h with nothing expected", opcode);
      end else begin
        exp_t e;
        exp_t a;
        e = sb.pop_front();
        a = '{opc: opcode, rd: rd, rs: rs, imm: imm, halt: is_halt, ill: illegal};
        if (a !== e) begin
          errors++;
          $display("FAIL out_fields: got %h required %h", a, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    valid_i = 1'b1;
    insn = v_insn[i];
    while (!done && n < 50) begin
      @(negedge clk);
      if (stall_o === 1'b0) begin
        sb.push_back(v_exp[i]);
        done = 1;
      end
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %h never accepted, required acceptance", v_insn[i]);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    v_insn[0] = 32'h04210005; v_exp[0] = '{6'd1, 5'd1, 5'd1, 32'h00000005, 1'b0, 1'b0};
    v_insn[1] = 32'h0842FFFF; v_exp[1] = '{6'd2, 5'd2, 5'd2, 32'hFFFFFFFF, 1'b0, 1'b0};
    v_insn[2] = 32'h0C631234; v_exp[2] = '{6'd3, 5'd3, 5'd3, 32'h00001234, 1'b0, 1'b0};
    v_insn[3] = 32'h10848000; v_exp[3] = '{6'd4, 5'd4, 5'd4, 32'hFFFF8000, 1'b0, 1'b0};
    v_insn[4] = 32'h14A57FFF; v_exp[4] = '{6'd5, 5'd5, 5'd5, 32'h00007FFF, 1'b0, 1'b0};
    v_insn[5] = 32'hFC000000; v_exp[5] = '{6'h3F, 5'd0, 5'd0, 32'h0, 1'b1, 1'b0};
    v_insn[6] = 32'h18C60042; v_exp[6] = '{6'd6, 5'd6, 5'd6, 32'h00000042, 1'b0, 1'b0};
    v_insn[7] = 32'h80000000; v_exp[7] = '{6'h20, 5'd0, 5'd0, 32'h0, 1'b0, ILL_ON};
    v_insn[8] = 32'h7C000001; v_exp[8] = '{6'h1F, 5'd0, 5'd0, 32'h1, 1'b0, 1'b0};
    v_insn[9] = 32'h00000000; v_exp[9] = '{6'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0};

    // Reset with valid_i asserted
    rst = 1'b0; valid_i = 1'b1; stall_i = 1'b0; insn = v_insn[0];
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_valid_o", 64'(valid_o), 64'd0);
      chk("rst_stall_o", 64'(stall_o), 64'd0);
      chk("rst_halted",  64'(halted),  64'd0);
    end
    chk("rst_fields", {opcode, rd, rs, imm, is_halt, illegal}, 64'd0);
    valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Streaming
    send(0);
    chk("latency_valid_o", 64'(valid_o), 64'd1);
    send(1);
    chk("stream_stall_o", 64'(stall_o), 64'd0);
    tick();

    // Skid: three stalled cycles, one word captured
    send(2);
    stall_i = 1'b1;
    send(3);
    valid_i = 1'b1; insn = v_insn[4];
    @(negedge clk);
    chk("skid_stall_o_1", 64'(stall_o), 64'd1);
    tick();
    @(negedge clk);
    chk("skid_stall_o_2", 64'(stall_o), 64'd1);
    chk("skid_held_valid", 64'(valid_o), 64'd1);
    tick();
    stall_i = 1'b0;
    send(4);
    repeat (3) tick();
    chk("skid_drained", 64'(sb.size()), 64'd0);

    // HALT blocks further intake until reset
    send(0);
    send(5);
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_stall_o", 64'(stall_o), 64'd1);
    valid_i = 1'b1; insn = v_insn[6];
    repeat (4) begin
      tick();
      chk("halt_hold", {62'd0, stall_o, halted}, 64'd3);
    end
    chk("halt_all_out", 64'(sb.size()), 64'd0);
    rst = 1'b0;
    tick();
    chk("halt_rst", {61'd0, valid_o, stall_o, halted}, 64'd0);
    rst = 1'b1;
    send(6);
    repeat (2) tick();

    // Reset while skid full and output stalled
    send(2);
    stall_i = 1'b1;
    send(3);
    chk("mid_skid_full", 64'(stall_o), 64'd1);
    rst = 1'b0;
    tick();
    sb.delete();
    chk("mid_rst_outs", {62'd0, valid_o, stall_o}, 64'd0);
    rst = 1'b1;
    stall_i = 1'b0;
    repeat (2) tick();
    chk("mid_rst_idle", 64'(valid_o), 64'd0);

    // Illegal opcode and highest legal opcode
    send(7);
    send(8);
    send(9);
    repeat (4) tick();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
